// File: rtl/r_ifetch.sv
// Instruction fetch stage: PC, one-cycle synchronous IMEM read, instruction register
// presented to the execute stage under valid/ready. A HALT word stops fetching until reset.
module r_ifetch #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [5:0]        OP,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        func,
    output logic [ADDR_W+1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_VALID,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W+1:0]   pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                halted_q, halted_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_ISSUE;
            pc_q      <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        imem_en   = 1'b0;
        case (state_q)
            S_ISSUE: begin
                imem_en = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                instr_d = imem_data;
                if (imem_data == HALT_WORD) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_VALID;
                    valid_d = 1'b1;
                end
            end
            S_VALID: begin
                // ready is only honoured here, so an early ready can never skip a word
                if (instr_ready) begin
                    valid_d   = 1'b0;
                    retired_d = retired_q + CNT_W'(1);
                    pc_d      = pc_q + (ADDR_W+2)'(4);
                    state_d   = S_ISSUE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase
    end

    assign imem_addr   = pc_q[ADDR_W+1:2];
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign OP          = instr_q[31:26];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign func        = instr_q[5:0];
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule
